// File: rtl/rd_wr_pkg.sv
// Shared types and helpers for the rd/wr burst generator.
//   state_t    : burst FSM states
//   Def*       : default parameter values used by the top
//   clamp_len  : clamps a requested rd burst length into [min_rd, max_rd]
//   len_out_of_range : flags a request that needed clamping
package rd_wr_pkg;

  localparam int unsigned DefMinRd     = 2;
  localparam int unsigned DefMaxRd     = 5;
  localparam int unsigned DefLenW      = 3;
  localparam int unsigned DefGapCycles = 1;
  localparam int unsigned DefDepth     = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StGap,
    StRd,
    StTail
  } state_t;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned min_rd,
                                            input int unsigned max_rd);
    if (len < min_rd) return min_rd;
    if (len > max_rd) return max_rd;
    return len;
  endfunction

  function automatic logic len_out_of_range(input int unsigned len,
                                            input int unsigned min_rd,
                                            input int unsigned max_rd);
    return (len < min_rd) || (len > max_rd);
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO holding clamped burst lengths.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous reset, active-high (flushes pointers and count)
//   push_i   : write data_i when not full (ignored when full)
//   data_i   : entry to enqueue
//   pop_i    : drop head when not empty
//   data_o   : current head entry
//   full_o   : count == Depth
//   empty_o  : count == 0
//   count_o  : number of stored entries
module req_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rd_wr_burst_gen.sv
// rd/wr strobe burst generator. Each queued request yields a 1-cycle wr pulse,
// GapCycles idle cycles, rd high for the clamped request length, then a TAIL
// cycle (done pulse, rd low) before the next request may start.
// Ports:
//   clk       : clock, all logic on posedge
//   rst       : synchronous reset, active-high
//   req_valid : request present
//   req_len   : requested rd burst length (clamped to [MinRd, MaxRd])
//   req_ready : queue can accept (= !full)
//   wr        : write strobe, one pulse per request
//   rd        : read strobe, high for the clamped length
//   busy      : FSM active or queue non-empty
//   done      : 1-cycle pulse in TAIL
//   len_err   : 1-cycle pulse the cycle after an accepted out-of-range req_len
module rd_wr_burst_gen
  import rd_wr_pkg::*;
#(
  parameter int unsigned MinRd     = DefMinRd,
  parameter int unsigned MaxRd     = DefMaxRd,
  parameter int unsigned LenW      = DefLenW,
  parameter int unsigned GapCycles = DefGapCycles,
  parameter int unsigned Depth     = DefDepth
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [LenW-1:0] req_len,
  output logic            req_ready,
  output logic            wr,
  output logic            rd,
  output logic            busy,
  output logic            done,
  output logic            len_err
);

  localparam int unsigned CntW     = $clog2(MaxRd + 1);
  localparam int unsigned GapW     = $clog2(GapCycles + 1);
  localparam int unsigned FifoCntW = $clog2(Depth + 1);

  state_t              state_q, state_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [CntW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic                wr_q, rd_q, done_q, len_err_q;

  logic                accept;
  logic [LenW-1:0]     len_clamped;
  logic                len_bad;
  logic                pop;
  logic                fifo_full, fifo_empty;
  logic [LenW-1:0]     fifo_head;
  logic [FifoCntW-1:0] fifo_count;

  assign req_ready   = !fifo_full;
  assign accept      = req_valid && req_ready;
  assign len_clamped = LenW'(clamp_len(32'(req_len), MinRd, MaxRd));
  assign len_bad     = len_out_of_range(32'(req_len), MinRd, MaxRd);

  req_fifo #(
    .Depth (Depth),
    .Width (LenW)
  ) u_req_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (req_valid),
    .data_i  (len_clamped),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state logic. The gap counter runs 1..GapCycles, the rd counter 1..len_q.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_cnt_d  = rd_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle, StTail: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          len_d   = fifo_head;
          state_d = StWr;
        end else begin
          state_d = StIdle;
        end
      end
      StWr: begin
        state_d   = StGap;
        gap_cnt_d = GapW'(1);
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GapCycles)) begin
          state_d  = StRd;
          rd_cnt_d = CntW'(1);
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      StRd: begin
        if (rd_cnt_q == CntW'(len_q)) begin
          state_d = StTail;
        end else begin
          rd_cnt_d = rd_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      gap_cnt_q <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      wr_q      <= (state_d == StWr);
      rd_q      <= (state_d == StRd);
      done_q    <= (state_d == StTail);
      len_err_q <= accept && len_bad;
    end
  end

  assign wr      = wr_q;
  assign rd      = rd_q;
  assign done    = done_q;
  assign len_err = len_err_q;
  assign busy    = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_rd_wr_burst_gen.sv
// Self-checking bench for rd_wr_burst_gen. A transaction-level reference model
// keeps the pending request lengths in a queue and, when a burst starts,
// expands it into the per-cycle event sequence wr, gap.., rd.., done.
module tb_rd_wr_burst_gen;

  localparam int unsigned Depth = 2;
  localparam int unsigned Gap   = 1;
  localparam int unsigned MinRd = 2;
  localparam int unsigned MaxRd = 5;

  localparam int unsigned EvNone = 0;
  localparam int unsigned EvWr   = 1;
  localparam int unsigned EvGap  = 2;
  localparam int unsigned EvRd   = 3;
  localparam int unsigned EvDone = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_len;
  logic       req_ready, wr, rd, busy, done, len_err;

  always #5 clk = ~clk;

  rd_wr_burst_gen dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_ready (req_ready),
    .wr        (wr),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  int unsigned q_len[$];
  int unsigned pat[$];
  int unsigned cur_ev      = EvNone;
  bit          exp_len_err = 1'b0;
  int unsigned rd_run      = 0;
  bit          rec_en      = 1'b0;
  int unsigned wr_times[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned clamp_model(input int unsigned l);
    return (l < MinRd) ? MinRd : ((l > MaxRd) ? MaxRd : l);
  endfunction

  // One clock edge of the reference model, using the inputs seen at that edge.
  task automatic model_step(input bit v, input int unsigned l, input bit r);
    bit          acc;
    int unsigned b;
    if (r) begin
      q_len.delete();
      pat.delete();
      cur_ev      = EvNone;
      exp_len_err = 1'b0;
      return;
    end
    acc = v && (q_len.size() < Depth);
    // A burst may start when nothing is scheduled beyond the current cycle.
    if (pat.size() == 0 && q_len.size() != 0) begin
      b = q_len.pop_front();
      pat.push_back(EvWr);
      repeat (Gap) pat.push_back(EvGap);
      repeat (b) pat.push_back(EvRd);
      pat.push_back(EvDone);
    end
    if (acc) q_len.push_back(clamp_model(l));
    exp_len_err = acc && (l < MinRd || l > MaxRd);
    cur_ev = (pat.size() != 0) ? pat.pop_front() : EvNone;
  endtask

  // Drive inputs at a negedge, advance one clock, then compare on the next negedge.
  task automatic cycle(input bit v, input int unsigned l, input bit r);
    req_valid = v;
    req_len   = 3'(l);
    rst       = r;
    @(posedge clk);
    model_step(v, l, r);
    cyc++;
    @(negedge clk);
    check_eq("wr", wr, cur_ev == EvWr);
    check_eq("rd", rd, cur_ev == EvRd);
    check_eq("done", done, cur_ev == EvDone);
    check_eq("len_err", len_err, exp_len_err);
    check_eq("busy", busy, (cur_ev != EvNone) || (q_len.size() != 0));
    check_eq("req_ready", req_ready, q_len.size() < Depth);
    // rd burst shape: every completed rd run is MinRd..MaxRd long.
    if (r) begin
      rd_run = 0;
    end else if (rd === 1'b1) begin
      rd_run++;
    end else if (rd_run != 0) begin
      check_eq("rd_run_in_range", (rd_run >= MinRd) && (rd_run <= MaxRd), 1);
      rd_run = 0;
    end
    if (rec_en && wr === 1'b1) wr_times.push_back(cyc);
  endtask

  task automatic push_req(input int unsigned l);
    bit took = 1'b0;
    int unsigned tries = 0;
    while (!took && tries < 40) begin
      took = req_ready;
      cycle(1'b1, l, 1'b0);
      tries++;
    end
    check_eq("push_accepted", took, 1);
  endtask

  task automatic run_single(input int unsigned l, input int unsigned exp_rd,
                            input bit exp_err, input string tag);
    int unsigned n_rd = 0;
    int unsigned n_done = 0;
    int unsigned n_wr = 0;
    bit saw_err;
    cycle(1'b1, l, 1'b0);
    saw_err = len_err;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 0, 1'b0);
      if (rd === 1'b1) n_rd++;
      if (done === 1'b1) n_done++;
      if (wr === 1'b1) n_wr++;
    end
    check_eq({tag, "_rd_len"}, n_rd, exp_rd);
    check_eq({tag, "_done_cnt"}, n_done, 1);
    check_eq({tag, "_wr_cnt"}, n_wr, 1);
    check_eq({tag, "_len_err"}, saw_err, exp_err);
  endtask

  initial begin
    int unsigned n_wr_t1;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_len   = '0;
    @(negedge clk);

    // Reset held with a request pending: nothing may be queued.
    repeat (3) cycle(1'b1, 3, 1'b1);
    n_wr_t1 = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 0, 1'b0);
      if (wr === 1'b1) n_wr_t1++;
    end
    check_eq("t1_no_wr_after_reset", n_wr_t1, 0);

    // Single request and clamping.
    run_single(3, 3, 1'b0, "t2_len3");
    run_single(0, 2, 1'b1, "t3_len0");
    run_single(7, 5, 1'b1, "t3_len7");

    // Back-to-back requests: wr period = 1 + Gap + len + 1.
    rec_en = 1'b1;
    wr_times.delete();
    push_req(2);
    push_req(5);
    push_req(4);
    repeat (30) cycle(1'b0, 0, 1'b0);
    rec_en = 1'b0;
    check_eq("t4_wr_count", wr_times.size(), 3);
    if (wr_times.size() >= 3) begin
      check_eq("t4_period0", wr_times[1] - wr_times[0], 5);
      check_eq("t4_period1", wr_times[2] - wr_times[1], 8);
    end

    // Reset on the second rd cycle of a len-5 burst.
    cycle(1'b1, 5, 1'b0);
    for (int i = 0; i < 10 && rd !== 1'b1; i++) cycle(1'b0, 0, 1'b0);
    check_eq("t5_rd_seen", rd, 1);
    cycle(1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1);
    check_eq("t5_rd_dropped", rd, 0);
    check_eq("t5_idle_after_rst", busy, 0);
    run_single(3, 3, 1'b0, "t5_after");

    // Queue kept full: pushes while full are dropped, pops still drain in order.
    for (int i = 0; i < 40; i++) cycle(1'b1, 2 + (i % 4), 1'b0);
    repeat (25) cycle(1'b0, 0, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 199) == 0);
    end
    repeat (25) cycle(1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
